// File: rtl/tick_ctrl_pkg.sv
// Shared constants for the tick controller: FSM encodings, mode values and reset prescale.
package tick_ctrl_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   // 50 MHz / (49999 + 1) = 1 kHz tick
   localparam int unsigned PRESCALE_DEFAULT = 49999;

endpackage

// File: rtl/tick_prescaler.sv
// Reloadable down-counter; wraps every period+1 enabled cycles with a registered pulse.
module tick_prescaler
   import tick_ctrl_pkg::*;
#(
   parameter int unsigned NBIT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   input  logic            load,
   input  logic [NBIT-1:0] period,
   output logic            wrap_c,
   output logic            wrap
);

   logic [NBIT-1:0] cnt;

   // Wrap condition is exposed combinationally so the owner can act on the same edge.
   assign wrap_c = enable && (cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         wrap <= 1'b0;
      end else begin
         wrap <= wrap_c;
         if (load || wrap_c) begin
            cnt <= period;
         end else if (enable) begin
            cnt <= cnt - NBIT'(1);
         end
      end
   end

endmodule

// File: rtl/tick_ctrl.sv
// Programmable tick controller: prescaler, one-shot/periodic interval sequencer, load handshake.
// Optional freeze input PAUSE is built when TICK_CTRL_PAUSE_EN is defined.
module tick_ctrl #(
   parameter int unsigned NBIT             = 16,
   parameter int unsigned CNT_W            = 16,
   parameter int unsigned PRESCALE_DEFAULT = tick_ctrl_pkg::PRESCALE_DEFAULT
) (
   input  logic             CLOCK_IN,
   input  logic             RESET,
   input  logic             LOAD_REQ,
   input  logic [NBIT-1:0]  LOAD_PERIOD,
   output logic             LOAD_ACK,
   input  logic             START,
   input  logic             STOP,
   input  logic             MODE,
   input  logic [CNT_W-1:0] INTERVAL,
`ifdef TICK_CTRL_PAUSE_EN
   input  logic             PAUSE,
`endif
   output logic             TICK,
   output logic             DONE,
   output logic             BUSY,
   output logic             CLK_OUT
);

   import tick_ctrl_pkg::*;

   logic [0:0]       state, state_nxt;
   logic [NBIT-1:0]  period_r, period_nxt;
   logic [CNT_W-1:0] ivl_r, ivl_r_nxt;
   logic [CNT_W-1:0] ivl_cnt, ivl_cnt_nxt;
   logic             mode_r, mode_nxt;
   logic             busy, busy_nxt;
   logic             load_ack, load_ack_nxt;
   logic             done, done_nxt;
   logic             clk_out, clk_out_nxt;
   logic             pre_load, pre_en, wrap_c, wrap;

   tick_prescaler #(.NBIT(NBIT)) u_prescaler (
      .clk    (CLOCK_IN),
      .rst    (RESET),
      .enable (pre_en),
      .load   (pre_load),
      .period (period_r),
      .wrap_c (wrap_c),
      .wrap   (wrap)
   );

   // Next-state and next-output logic
   always_comb begin
      state_nxt    = state;
      period_nxt   = period_r;
      ivl_r_nxt    = ivl_r;
      ivl_cnt_nxt  = ivl_cnt;
      mode_nxt     = mode_r;
      busy_nxt     = busy;
      load_ack_nxt = 1'b0;
      done_nxt     = 1'b0;
      clk_out_nxt  = clk_out;
      pre_load     = 1'b0;
      pre_en       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!STOP) begin
               if (LOAD_REQ) begin
                  period_nxt   = LOAD_PERIOD;
                  load_ack_nxt = 1'b1;
               end else if (START && (INTERVAL != '0)) begin
                  ivl_r_nxt   = INTERVAL;
                  ivl_cnt_nxt = INTERVAL;
                  mode_nxt    = MODE;
                  pre_load    = 1'b1;
                  state_nxt   = ST_RUN;
                  busy_nxt    = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (STOP) begin
               state_nxt = ST_IDLE;
               busy_nxt  = 1'b0;
            end else begin
               pre_en = 1'b1;
`ifdef TICK_CTRL_PAUSE_EN
               if (PAUSE) pre_en = 1'b0;
`endif
               if (wrap_c) begin
                  clk_out_nxt = ~clk_out;
                  if (ivl_cnt == CNT_W'(1)) begin
                     done_nxt = 1'b1;
                     if (mode_r == MODE_PERIODIC) begin
                        ivl_cnt_nxt = ivl_r;
                     end else begin
                        ivl_cnt_nxt = '0;
                        state_nxt   = ST_IDLE;
                        busy_nxt    = 1'b0;
                     end
                  end else begin
                     ivl_cnt_nxt = ivl_cnt - CNT_W'(1);
                  end
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLOCK_IN or posedge RESET) begin
      if (RESET) begin
         state    <= ST_IDLE;
         period_r <= NBIT'(PRESCALE_DEFAULT);
         ivl_r    <= '0;
         ivl_cnt  <= '0;
         mode_r   <= MODE_ONESHOT;
         busy     <= 1'b0;
         load_ack <= 1'b0;
         done     <= 1'b0;
         clk_out  <= 1'b0;
      end else begin
         state    <= state_nxt;
         period_r <= period_nxt;
         ivl_r    <= ivl_r_nxt;
         ivl_cnt  <= ivl_cnt_nxt;
         mode_r   <= mode_nxt;
         busy     <= busy_nxt;
         load_ack <= load_ack_nxt;
         done     <= done_nxt;
         clk_out  <= clk_out_nxt;
      end
   end

   assign TICK     = wrap;
   assign DONE     = done;
   assign BUSY     = busy;
   assign LOAD_ACK = load_ack;
   assign CLK_OUT  = clk_out;

endmodule

// File: tb/tb_tick_ctrl.sv
// Directed self-checking bench for tick_ctrl with hand-computed tick/done/busy/clk_out timelines.
`timescale 1ns/1ps
module tb_tick_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_req = 1'b0;
   logic [15:0] load_period = '0;
   logic        load_ack;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        mode = 1'b0;
   logic [15:0] interval = '0;
`ifdef TICK_CTRL_PAUSE_EN
   logic        pause = 1'b0;
`endif
   logic        tick, done, busy, clk_out;

   int vectors = 0;
   int miscompares = 0;
   logic clk_lvl = 1'b0;

   always #5 clk = ~clk;

   tick_ctrl #(.NBIT(16), .CNT_W(16), .PRESCALE_DEFAULT(49999)) dut (
      .CLOCK_IN    (clk),
      .RESET       (rst),
      .LOAD_REQ    (load_req),
      .LOAD_PERIOD (load_period),
      .LOAD_ACK    (load_ack),
      .START       (start),
      .STOP        (stop),
      .MODE        (mode),
      .INTERVAL    (interval),
`ifdef TICK_CTRL_PAUSE_EN
      .PAUSE       (pause),
`endif
      .TICK        (tick),
      .DONE        (done),
      .BUSY        (busy),
      .CLK_OUT     (clk_out)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] p);
      load_period = p;
      load_req = 1'b1;
      step();
      load_req = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      vectors++;
      if ({tick, done, busy, load_ack, clk_out} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_hold: got %b want 00000", {tick, done, busy, load_ack, clk_out});
      end
      rst = 1'b0;
      step();
      vectors++;
      if ({tick, done, busy, load_ack, clk_out} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_release: got %b want 00000", {tick, done, busy, load_ack, clk_out});
      end
   endtask

   task automatic test_load_oneshot();
      logic [3:0] exp;
      load_period = 16'd3;
      load_req = 1'b1;
      step();
      vectors++;
      if (load_ack !== 1'b1) begin
         miscompares++;
         $display("FAIL load_ack_pulse: got %b want 1", load_ack);
      end
      load_req = 1'b0;
      step();
      vectors++;
      if (load_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL load_ack_single: got %b want 0", load_ack);
      end
      mode = 1'b0;
      interval = 16'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      vectors++;
      if ({tick, done, busy} !== 3'b001) begin
         miscompares++;
         $display("FAIL oneshot_start: got %b want 001", {tick, done, busy});
      end
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k == 4 || k == 8) clk_lvl = ~clk_lvl;
         exp = {(k == 4 || k == 8), (k == 8), (k < 8), clk_lvl};
         vectors++;
         if ({tick, done, busy, clk_out} !== exp) begin
            miscompares++;
            $display("FAIL oneshot_cycle%0d: got %b want %b", k, {tick, done, busy, clk_out}, exp);
         end
      end
      step();
      vectors++;
      if ({tick, done, busy, clk_out} !== {3'b000, clk_lvl}) begin
         miscompares++;
         $display("FAIL oneshot_after: got %b want %b", {tick, done, busy, clk_out}, {3'b000, clk_lvl});
      end
   endtask

   task automatic test_periodic();
      logic [3:0] exp;
      do_load(16'd1);
      mode = 1'b1;
      interval = 16'd3;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k % 2 == 0) clk_lvl = ~clk_lvl;
         exp = {(k % 2 == 0), (k % 6 == 0), 1'b1, clk_lvl};
         vectors++;
         if ({tick, done, busy, clk_out} !== exp) begin
            miscompares++;
            $display("FAIL periodic_cycle%0d: got %b want %b", k, {tick, done, busy, clk_out}, exp);
         end
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      vectors++;
      if ({tick, done, busy, clk_out} !== {3'b000, clk_lvl}) begin
         miscompares++;
         $display("FAIL periodic_stop: got %b want %b", {tick, done, busy, clk_out}, {3'b000, clk_lvl});
      end
   endtask

   task automatic test_stop_on_wrap();
      logic [3:0] exp;
      do_load(16'd4);
      mode = 1'b0;
      interval = 16'd5;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         step();
         if (k == 5) clk_lvl = ~clk_lvl;
         exp = {(k == 5), 1'b0, 1'b1, clk_lvl};
         vectors++;
         if ({tick, done, busy, clk_out} !== exp) begin
            miscompares++;
            $display("FAIL stopwrap_cycle%0d: got %b want %b", k, {tick, done, busy, clk_out}, exp);
         end
      end
      // counter is at zero for the next edge: STOP must suppress that wrap
      stop = 1'b1;
      step();
      stop = 1'b0;
      vectors++;
      if ({tick, done, busy, clk_out} !== {3'b000, clk_lvl}) begin
         miscompares++;
         $display("FAIL stopwrap_edge: got %b want %b", {tick, done, busy, clk_out}, {3'b000, clk_lvl});
      end
      step();
      vectors++;
      if ({tick, done, busy, clk_out} !== {3'b000, clk_lvl}) begin
         miscompares++;
         $display("FAIL stopwrap_idle: got %b want %b", {tick, done, busy, clk_out}, {3'b000, clk_lvl});
      end
   endtask

   task automatic test_load_in_run();
      logic [4:0] exp;
      logic [3:0] exp4;
      mode = 1'b0;
      interval = 16'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      load_period = 16'd9;
      load_req = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         start = (k == 3);
         step();
         if (k == 5 || k == 10) clk_lvl = ~clk_lvl;
         exp = {(k == 5 || k == 10), (k == 10), (k < 10), 1'b0, clk_lvl};
         vectors++;
         if ({tick, done, busy, load_ack, clk_out} !== exp) begin
            miscompares++;
            $display("FAIL runload_cycle%0d: got %b want %b", k, {tick, done, busy, load_ack, clk_out}, exp);
         end
      end
      start = 1'b0;
      step();
      vectors++;
      if ({busy, load_ack} !== 2'b01) begin
         miscompares++;
         $display("FAIL runload_ack: got %b want 01", {busy, load_ack});
      end
      load_req = 1'b0;
      step();
      vectors++;
      if (load_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL runload_ack_drop: got %b want 0", load_ack);
      end
      mode = 1'b1;
      interval = 16'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k % 10 == 0) clk_lvl = ~clk_lvl;
         exp4 = {(k % 10 == 0), (k == 20), 1'b1, clk_lvl};
         vectors++;
         if ({tick, done, busy, clk_out} !== exp4) begin
            miscompares++;
            $display("FAIL p9_cycle%0d: got %b want %b", k, {tick, done, busy, clk_out}, exp4);
         end
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL p9_stop: got %b want 0", busy);
      end
   endtask

   task automatic test_p0_and_zero_interval();
      do_load(16'd0);
      mode = 1'b0;
      interval = 16'd1;
      start = 1'b1;
      step();
      start = 1'b0;
      vectors++;
      if ({tick, done, busy} !== 3'b001) begin
         miscompares++;
         $display("FAIL p0_start: got %b want 001", {tick, done, busy});
      end
      step();
      clk_lvl = ~clk_lvl;
      vectors++;
      if ({tick, done, busy, clk_out} !== {3'b110, clk_lvl}) begin
         miscompares++;
         $display("FAIL p0_tick: got %b want %b", {tick, done, busy, clk_out}, {3'b110, clk_lvl});
      end
      step();
      vectors++;
      if ({tick, done, busy, clk_out} !== {3'b000, clk_lvl}) begin
         miscompares++;
         $display("FAIL p0_after: got %b want %b", {tick, done, busy, clk_out}, {3'b000, clk_lvl});
      end
      interval = 16'd0;
      start = 1'b1;
      step();
      vectors++;
      if ({tick, busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL zero_ivl_1: got %b want 00", {tick, busy});
      end
      step();
      start = 1'b0;
      vectors++;
      if ({tick, busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL zero_ivl_2: got %b want 00", {tick, busy});
      end
   endtask

   task automatic test_reset_mid_run();
      int n;
      do_load(16'd9);
      mode = 1'b0;
      interval = 16'd3;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k == 10) clk_lvl = ~clk_lvl;
         vectors++;
         if ({tick, done, busy} !== {(k == 10), 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL midrun_cycle%0d: got %b want %b", k, {tick, done, busy}, {(k == 10), 2'b01});
         end
      end
      rst = 1'b1;
      #1;
      clk_lvl = 1'b0;
      vectors++;
      if ({tick, done, busy, load_ack, clk_out} !== 5'b0) begin
         miscompares++;
         $display("FAIL midrun_reset: got %b want 00000", {tick, done, busy, load_ack, clk_out});
      end
      step();
      step();
      rst = 1'b0;
      step();
      vectors++;
      if ({tick, done, busy, load_ack, clk_out} !== 5'b0) begin
         miscompares++;
         $display("FAIL midrun_post: got %b want 00000", {tick, done, busy, load_ack, clk_out});
      end
      // default period must be back: first tick 50000 cycles after START
      interval = 16'd1;
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (tick !== 1'b1 && n < 60000) begin
         step();
         n++;
      end
      vectors++;
      if (n != 50000) begin
         miscompares++;
         $display("FAIL default_period: got %0d cycles want 50000", n);
      end
      vectors++;
      if ({done, busy} !== 2'b10) begin
         miscompares++;
         $display("FAIL default_done: got %b want 10", {done, busy});
      end
   endtask

   initial begin
      test_reset();
      test_load_oneshot();
      test_periodic();
      test_stop_on_wrap();
      test_load_in_run();
      test_p0_and_zero_interval();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
